// File: rtl/servo_pwm_gen.sv
// Hobby-servo PWM generator: one pulse per PERIOD_CYC-cycle frame, pulse width
// linear in an angle that is sampled only at frame boundaries.
module servo_pwm_gen #(
    parameter int PERIOD_CYC    = 1000000,
    parameter int MIN_PULSE_CYC = 50000,
    parameter int DEG_CYC       = 278,
    parameter int MAX_ANGLE     = 180,
    parameter int RST_ANGLE     = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] angle,
    output logic       pwm_out,
    output logic       frame_start,
    output logic       active,
    output logic [7:0] cur_angle,
    output logic       clamped
);
    localparam int CW = $clog2(PERIOD_CYC);
    localparam logic [CW-1:0] LAST = CW'(PERIOD_CYC - 1);

    generate
        if (MIN_PULSE_CYC + MAX_ANGLE * DEG_CYC >= PERIOD_CYC) begin : g_bad_params
            $error("servo_pwm_gen: maximum pulse does not fit inside the frame");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt, width, width_nxt;
    logic [7:0]    a;
    logic          over, start;

    assign over      = angle > 8'(MAX_ANGLE);
    assign a         = over ? 8'(MAX_ANGLE) : angle;
    assign width_nxt = CW'(MIN_PULSE_CYC) + CW'(a) * CW'(DEG_CYC);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    start     = 1'b1;
                    state_nxt = HIGH;
                    cnt_nxt   = '0;
                end
            end
            HIGH: begin
                cnt_nxt = cnt + CW'(1);
                if (cnt == width - CW'(1)) state_nxt = LOW;
            end
            LOW: begin
                if (cnt == LAST) begin
                    // frame boundary: either chain straight into the next frame or stop
                    cnt_nxt = '0;
                    if (en) begin
                        start     = 1'b1;
                        state_nxt = HIGH;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            width       <= '0;
            cur_angle   <= 8'(RST_ANGLE);
            clamped     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            frame_start <= start;
            if (start) begin
                cur_angle <= a;
                clamped   <= over;
                width     <= width_nxt;
            end
        end
    end

    assign pwm_out = (state == HIGH);
    assign active  = (state != IDLE);
endmodule

// File: tb/tb_servo_pwm_gen.sv
// Self-checking bench for servo_pwm_gen: directed frame measurements plus a
// randomized run checked every cycle against a frame-position reference model.
module tb_servo_pwm_gen;
    localparam int P  = 1000;
    localparam int MN = 100;
    localparam int DG = 2;
    localparam int MX = 180;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [7:0] angle = 8'd0;
    logic       pwm_out, frame_start, active, clamped;
    logic [7:0] cur_angle;

    int checks = 0;
    int failures = 0;
    bit mon = 1'b0;

    servo_pwm_gen #(
        .PERIOD_CYC(P), .MIN_PULSE_CYC(MN), .DEG_CYC(DG), .MAX_ANGLE(MX), .RST_ANGLE(60)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .angle(angle),
        .pwm_out(pwm_out), .frame_start(frame_start), .active(active),
        .cur_angle(cur_angle), .clamped(clamped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: position within the current frame (-1 = idle) and the latched pulse width.
    int   m_pos = -1;
    int   m_w = 0;
    int   m_ang = 60;
    bit   m_clamp = 1'b0;
    bit   m_fs = 1'b0;
    wire  m_start = ((m_pos == -1) || (m_pos == P - 1)) && en;
    wire  [7:0] m_sa = (angle > 8'(MX)) ? 8'(MX) : angle;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pos <= -1; m_w <= 0; m_ang <= 60; m_clamp <= 1'b0; m_fs <= 1'b0;
        end else begin
            m_fs <= m_start;
            if (m_start) begin
                m_pos   <= 0;
                m_ang   <= int'(m_sa);
                m_clamp <= angle > 8'(MX);
                m_w     <= MN + int'(m_sa) * DG;
            end else if (m_pos == P - 1) begin
                m_pos <= -1;
            end else if (m_pos >= 0) begin
                m_pos <= m_pos + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (mon) begin
            chk("m_pwm", pwm_out, (m_pos >= 0 && m_pos < m_w));
            chk("m_fs", frame_start, m_fs);
            chk("m_active", active, (m_pos >= 0));
            chk("m_angle", cur_angle, m_ang);
            chk("m_clamped", clamped, m_clamp);
        end
    end

    task automatic wait_fs();
        int n = 0;
        while (!frame_start && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!frame_start) chk("fs_timeout", 0, 1);
    endtask

    // Called on the negedge where frame_start is seen; returns on the first
    // negedge of the next frame (or of idle). Optionally changes inputs mid-frame.
    task automatic measure(input int chg_at, input logic [7:0] nang, input logic nen,
                           output int hi, output int len, output int ca, output int cl);
        hi = 0; len = 0; ca = int'(cur_angle); cl = int'(clamped);
        do begin
            if (len == chg_at) begin
                angle = nang;
                en    = nen;
            end
            if (pwm_out) hi++;
            len++;
            @(negedge clk);
        end while (!frame_start && active && len < 3000);
    endtask

    initial begin
        int hi, len, ca, cl, bad;
        repeat (3) @(negedge clk);
        mon = 1'b1;
        chk("rst_pwm", pwm_out, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_active", active, 0);
        chk("rst_angle", cur_angle, 60);
        chk("rst_clamped", clamped, 0);

        // basic frames at angle 0, then contiguous frames with new angles
        rst = 1'b1; angle = 8'd0; en = 1'b1;
        wait_fs();
        measure(-1, 0, 1, hi, len, ca, cl);
        chk("a0_high", hi, 100); chk("a0_len", len, 1000);
        chk("a0_angle", ca, 0); chk("a0_clamped", cl, 0);
        chk("b2b_fs", frame_start, 1);
        angle = 8'd180;
        measure(-1, 0, 1, hi, len, ca, cl);
        chk("a180_old_high", hi, 100); chk("b2b_len2", len, 1000);
        angle = 8'd200;
        measure(-1, 0, 1, hi, len, ca, cl);
        chk("a180_high", hi, 460); chk("a180_angle", ca, 180); chk("a180_clamped", cl, 0);
        chk("b2b_len3", len, 1000);
        angle = 8'd90;
        measure(-1, 0, 1, hi, len, ca, cl);
        chk("a200_high", hi, 460); chk("a200_angle", ca, 180); chk("a200_clamped", cl, 1);

        // angle change mid-frame is held off until the next boundary
        measure(50, 30, 1, hi, len, ca, cl);
        chk("a90_high", hi, 280); chk("a90_angle", ca, 90);
        angle = 8'd90;
        measure(-1, 0, 1, hi, len, ca, cl);
        chk("a30_high", hi, 160); chk("a30_angle", ca, 30);

        // en dropped mid-pulse: pulse and frame complete, then quiet
        measure(50, 90, 0, hi, len, ca, cl);
        chk("endrop_high", hi, 280); chk("endrop_len", len, 1000);
        bad = 0;
        repeat (1200) begin
            if (frame_start || pwm_out || active) bad++;
            @(negedge clk);
        end
        chk("idle_quiet", bad, 0);

        // async reset in the middle of a pulse
        en = 1'b1;
        @(negedge clk);
        chk("idle_start_fs", frame_start, 1);
        repeat (20) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_pwm", pwm_out, 0);
        chk("arst_active", active, 0);
        chk("arst_angle", cur_angle, 60);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rel_fs", frame_start, 1);
        chk("rel_pwm", pwm_out, 1);
        measure(-1, 0, 1, hi, len, ca, cl);
        chk("rel_high", hi, 280); chk("rel_len", len, 1000);

        // randomized run; per-cycle model checks carry the verification
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 299) == 0) en = ~en;
            if ($urandom_range(0, 49) == 0) angle = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 4999) == 0) rst = 1'b0;
            else rst = 1'b1;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        mon = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
